// File: rtl/x7seg_scan_bcd_pkg.sv
// Shared types and constants for the scanned BCD 7-segment display driver.
// Segment patterns are active-low, bit6=a ... bit0=g.
package x7seg_scan_bcd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h7E;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_e;

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/x7seg_scan_bcd_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: load/busy/done handshake around an
// iterative double-dabble datapath that consumes one input bit per clock.
module x7seg_scan_bcd_bin2bcd_seq
  import x7seg_scan_bcd_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned N_DIG = 4
) (
  input  logic                 i_clk,
  input  logic                 i_clr,
  input  logic                 i_load,
  input  logic [IN_W-1:0]      i_x,
  output logic [4*N_DIG-1:0]   o_bcd,
  output logic                 o_overflow,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned BCD_W = 4 * N_DIG;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  state_e             r_state;
  logic [IN_W-1:0]    r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;

  logic [BCD_W-1:0]       w_adj;
  logic [BCD_W+IN_W-1:0]  w_shift;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < N_DIG; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // {bcd, bin} shifted left by one; w_adj's MSB falls off the top.
  assign w_shift = {w_adj[BCD_W-2:0], r_bin, 1'b0};

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      o_bcd      <= '0;
      o_overflow <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_load) begin
            r_bin   <= i_x;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= CNT_W'(IN_W);
            o_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          {r_bcd, r_bin} <= w_shift;
          if (w_adj[BCD_W-1]) begin
            r_ovf <= 1'b1;
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= LATCH;
          end
        end
        LATCH: begin
          o_bcd      <= r_bcd;
          o_overflow <= r_ovf;
          o_done     <= 1'b1;
          o_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/x7seg_scan_bcd.sv
// Time-multiplexed common-anode 7-segment driver with on-the-fly BCD
// conversion, leading-zero blanking, per-digit decimal point and overflow dashes.
module x7seg_scan_bcd
  import x7seg_scan_bcd_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned N_DIG = 4,
  parameter int unsigned DIV_W = 18
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [IN_W-1:0]    x,
  input  logic               load,
  input  logic               blank_lz,
  input  logic [N_DIG-1:0]   dp_mask,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [6:0]         a_to_g,
  output logic               dp,
  output logic [N_DIG-1:0]   an
);

  localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  logic [DIV_W-1:0]    r_pre;
  logic [IDX_W-1:0]    r_idx;

  logic [4*N_DIG-1:0]  w_bcd;
  logic [N_DIG-1:0]    w_blank;
  logic                w_run;
  logic [3:0]          w_digit;
  logic [6:0]          w_seg;

  x7seg_scan_bcd_bin2bcd_seq #(
    .IN_W  (IN_W),
    .N_DIG (N_DIG)
  ) u_conv (
    .i_clk      (clk),
    .i_clr      (clr),
    .i_load     (load),
    .i_x        (x),
    .o_bcd      (w_bcd),
    .o_overflow (overflow),
    .o_busy     (busy),
    .o_done     (done)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_pre <= '0;
      r_idx <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
      if (&r_pre) begin
        r_idx <= (r_idx == IDX_W'(N_DIG - 1)) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // A lit decimal point stops the zero run, so nothing at or right of it blanks.
  always_comb begin
    w_blank = '0;
    w_run   = blank_lz;
    for (int i = N_DIG - 1; i >= 1; i--) begin
      w_run      = w_run & (w_bcd[4*i +: 4] == 4'd0) & ~dp_mask[i];
      w_blank[i] = w_run;
    end
  end

  always_comb begin
    w_digit = w_bcd[4*r_idx +: 4];
    if (overflow) begin
      w_seg = SEG_DASH;
    end else if (w_blank[r_idx]) begin
      w_seg = SEG_BLANK;
    end else begin
      w_seg = seg_of(w_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      a_to_g <= SEG_BLANK;
      dp     <= 1'b1;
      an     <= '1;
    end else begin
      a_to_g <= w_seg;
      dp     <= ~dp_mask[r_idx];
      an     <= ~(N_DIG'(1) << r_idx);
    end
  end

endmodule

// File: tb/tb_x7seg_scan_bcd.sv
// Directed bench for x7seg_scan_bcd: a 4-digit and a 2-digit instance, DIV_W=2.
module tb_x7seg_scan_bcd;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'h7F;
  localparam logic [6:0] SD = 7'h7E;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] x4, x2;
  logic       load4, load2, blz4, blz2;
  logic [3:0] dpm4, an4;
  logic [1:0] dpm2, an2;
  logic       busy4, done4, ovf4, dp4;
  logic       busy2, done2, ovf2, dp2;
  logic [6:0] seg4, seg2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  x7seg_scan_bcd #(.IN_W(8), .N_DIG(4), .DIV_W(2)) u_dut4 (
    .clk(clk), .clr(clr), .x(x4), .load(load4), .blank_lz(blz4), .dp_mask(dpm4),
    .busy(busy4), .done(done4), .overflow(ovf4), .a_to_g(seg4), .dp(dp4), .an(an4)
  );

  x7seg_scan_bcd #(.IN_W(8), .N_DIG(2), .DIV_W(2)) u_dut2 (
    .clk(clk), .clr(clr), .x(x2), .load(load2), .blank_lz(blz2), .dp_mask(dpm2),
    .busy(busy2), .done(done2), .overflow(ovf2), .a_to_g(seg2), .dp(dp2), .an(an2)
  );

  // Drives a load now, then counts edges after acceptance until done (-1 on timeout).
  task automatic load_val(input bit sel2, input logic [7:0] v, output int lat);
    lat = -1;
    if (sel2) begin x2 = v; load2 = 1'b1; end
    else begin x4 = v; load4 = 1'b1; end
    @(posedge clk); #1;
    load2 = 1'b0;
    load4 = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if ((sel2 ? done2 : done4) === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic get_digit(input bit sel2, input int d, output logic [6:0] seg,
                           output logic dpv, output bit ok);
    ok  = 1'b0;
    seg = 'x;
    dpv = 1'bx;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (sel2 ? (an2 === ~(2'b01 << d)) : (an4 === ~(4'b0001 << d))) begin
        ok  = 1'b1;
        seg = sel2 ? seg2 : seg4;
        dpv = sel2 ? dp2 : dp4;
        break;
      end
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done4); end
    checks++; if (ovf4 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf4); end
    checks++; if (seg4 !== SB) begin errors++; $display("FAIL reset_seg: got %h want 7f", seg4); end
    checks++; if (dp4 !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", dp4); end
    checks++; if (an4 !== 4'hF) begin errors++; $display("FAIL reset_an: got %b want 1111", an4); end
    checks++; if (an2 !== 2'b11) begin errors++; $display("FAIL reset_an2: got %b want 11", an2); end
    clr = 1'b0;
  endtask

  task automatic test_convert;
    int lat;
    logic [6:0] e [4];
    logic [6:0] seg;
    logic dpv;
    bit ok;
    load_val(1'b0, 8'd255, lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL conv_latency: got %0d want 9", lat); end
    checks++; if (ovf4 !== 1'b0) begin errors++; $display("FAIL conv_ovf: got %b want 0", ovf4); end
    e[3] = S0; e[2] = S2; e[1] = S5; e[0] = S5;
    for (int d = 3; d >= 0; d--) begin
      get_digit(1'b0, d, seg, dpv, ok);
      checks++;
      if (!ok || seg !== e[d]) begin
        errors++; $display("FAIL conv_digit%0d: got %b want %b (found=%0d)", d, seg, e[d], ok);
      end
    end
  endtask

  task automatic test_blank;
    int lat;
    logic [6:0] e [4];
    logic [6:0] seg;
    logic dpv;
    bit ok;
    blz4 = 1'b1;
    e[3] = SB; e[2] = S2; e[1] = S5; e[0] = S5;
    for (int d = 3; d >= 0; d--) begin
      get_digit(1'b0, d, seg, dpv, ok);
      checks++;
      if (!ok || seg !== e[d]) begin
        errors++; $display("FAIL blank255_digit%0d: got %b want %b (found=%0d)", d, seg, e[d], ok);
      end
    end
    load_val(1'b0, 8'd0, lat);
    e[3] = SB; e[2] = SB; e[1] = SB; e[0] = S0;
    for (int d = 3; d >= 0; d--) begin
      get_digit(1'b0, d, seg, dpv, ok);
      checks++;
      if (!ok || seg !== e[d]) begin
        errors++; $display("FAIL blank0_digit%0d: got %b want %b (found=%0d)", d, seg, e[d], ok);
      end
    end
    blz4 = 1'b0;
  endtask

  task automatic test_overflow;
    int lat;
    logic [6:0] seg;
    logic dpv;
    bit ok;
    load_val(1'b1, 8'd100, lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL ovf_latency: got %0d want 9", lat); end
    checks++; if (ovf2 !== 1'b1) begin errors++; $display("FAIL ovf100_flag: got %b want 1", ovf2); end
    for (int d = 1; d >= 0; d--) begin
      get_digit(1'b1, d, seg, dpv, ok);
      checks++;
      if (!ok || seg !== SD) begin
        errors++; $display("FAIL ovf100_digit%0d: got %b want %b (found=%0d)", d, seg, SD, ok);
      end
    end
    load_val(1'b1, 8'd99, lat);
    checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL ovf99_flag: got %b want 0", ovf2); end
    for (int d = 1; d >= 0; d--) begin
      get_digit(1'b1, d, seg, dpv, ok);
      checks++;
      if (!ok || seg !== S9) begin
        errors++; $display("FAIL ovf99_digit%0d: got %b want %b (found=%0d)", d, seg, S9, ok);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [6:0] seg;
    logic dpv;
    bit ok;
    x4 = 8'd12;
    load4 = 1'b1;
    @(posedge clk); #1;
    load4 = 1'b0;
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy4); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    x4 = 8'd34;
    load4 = 1'b1;
    @(posedge clk); #1;
    load4 = 1'b0;
    lat = -1;
    for (int n = 4; n <= 30; n++) begin
      @(posedge clk); #1;
      if (done4 === 1'b1) begin lat = n; break; end
    end
    checks++; if (lat !== 9) begin errors++; $display("FAIL b2b_ignored_latency: got %0d want 9", lat); end
    get_digit(1'b0, 1, seg, dpv, ok);
    checks++; if (!ok || seg !== S1) begin errors++; $display("FAIL b2b_12_digit1: got %b want %b", seg, S1); end
    get_digit(1'b0, 0, seg, dpv, ok);
    checks++; if (!ok || seg !== S2) begin errors++; $display("FAIL b2b_12_digit0: got %b want %b", seg, S2); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL b2b_no_queue: busy got %b want 0", busy4); end
    // Reload in the done cycle: load_val returns with done high.
    load_val(1'b0, 8'd12, lat);
    load_val(1'b0, 8'd34, lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL b2b_done_cycle_latency: got %0d want 9", lat); end
    get_digit(1'b0, 1, seg, dpv, ok);
    checks++; if (!ok || seg !== S3) begin errors++; $display("FAIL b2b_34_digit1: got %b want %b", seg, S3); end
    get_digit(1'b0, 0, seg, dpv, ok);
    checks++; if (!ok || seg !== S4) begin errors++; $display("FAIL b2b_34_digit0: got %b want %b", seg, S4); end
  endtask

  task automatic test_dp_scan;
    int lat;
    logic [6:0] e [4];
    logic ed [4];
    logic [6:0] seg;
    logic dpv;
    bit ok;
    bit found;
    blz4 = 1'b1;
    dpm4 = 4'b0100;
    load_val(1'b0, 8'd5, lat);
    e[3] = SB; e[2] = S0; e[1] = S0; e[0] = S5;
    ed[3] = 1'b1; ed[2] = 1'b0; ed[1] = 1'b1; ed[0] = 1'b1;
    for (int d = 3; d >= 0; d--) begin
      get_digit(1'b0, d, seg, dpv, ok);
      checks++;
      if (!ok || seg !== e[d]) begin
        errors++; $display("FAIL dp_seg_digit%0d: got %b want %b (found=%0d)", d, seg, e[d], ok);
      end
      checks++;
      if (!ok || dpv !== ed[d]) begin
        errors++; $display("FAIL dp_dp_digit%0d: got %b want %b", d, dpv, ed[d]);
      end
    end
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (an4 === 4'b0111) begin found = 1'b1; break; end
    end
    if (found) begin
      found = 1'b0;
      for (int n = 0; n < 10; n++) begin
        @(posedge clk); #1;
        if (an4 === 4'b1110) begin found = 1'b1; break; end
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL scan_wrap: got an=%b want 0111 then 1110", an4);
    end else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (an4 !== ~(4'b0001 << (k / 4))) begin
          errors++; $display("FAIL scan_step%0d: got %b want %b", k, an4, ~(4'b0001 << (k / 4)));
        end
        @(posedge clk); #1;
      end
    end
    blz4 = 1'b0;
    dpm4 = 4'b0000;
  endtask

  task automatic test_clr_abort;
    logic [6:0] seg;
    logic dpv;
    bit ok;
    bit saw_done;
    x4 = 8'd200;
    load4 = 1'b1;
    @(posedge clk); #1;
    load4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", busy4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL clr_done: got %b want 0", done4); end
    checks++; if (an4 !== 4'hF) begin errors++; $display("FAIL clr_an: got %b want 1111", an4); end
    checks++; if (seg4 !== SB) begin errors++; $display("FAIL clr_seg: got %h want 7f", seg4); end
    clr = 1'b0;
    saw_done = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done4 === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL clr_no_done: got %b want 0", saw_done); end
    get_digit(1'b0, 3, seg, dpv, ok);
    checks++; if (!ok || seg !== S0) begin errors++; $display("FAIL clr_digit3: got %b want %b", seg, S0); end
    get_digit(1'b0, 0, seg, dpv, ok);
    checks++; if (!ok || seg !== S0) begin errors++; $display("FAIL clr_digit0: got %b want %b", seg, S0); end
    checks++; if (ovf4 !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b want 0", ovf4); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0;
    x4 = '0; x2 = '0;
    load4 = 1'b0; load2 = 1'b0;
    blz4 = 1'b0; blz2 = 1'b0;
    dpm4 = '0; dpm2 = '0;
    @(posedge clk); #1;
    test_reset();
    test_convert();
    test_blank();
    test_overflow();
    test_back_to_back();
    test_dp_scan();
    test_clr_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
